// File: rtl/waveform_stream_mc.sv
// rtl/waveform_stream_mc.sv - multi-slot waveform store: AXI-Stream load, repeat/gap replay
// Slots share one dual-port BRAM; load and playback FSMs run independently on distinct slots.
`timescale 1ns/1ps
module waveform_stream_mc #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 8,
  parameter int SLOT_BITS         = 2,
  parameter bit WRITE_BEFORE_READ = 1'b1
) (
  input  logic                      clk_in1,
  input  logic                      reset,
  input  logic [127:0]              waveform_parameters,
  input  logic                      init_wf_write,
  output logic                      wf_write_ready,
  input  logic                      init_wf_read,
  output logic                      wf_read_ready,
  input  logic [DATA_WIDTH-1:0]     wfin_axis_tdata,
  input  logic                      wfin_axis_tvalid,
  input  logic                      wfin_axis_tlast,
  input  logic [DATA_WIDTH/8-1:0]   wfin_axis_tkeep,
  output logic                      wfin_axis_tready,
  output logic [DATA_WIDTH-1:0]     wfout_axis_tdata,
  output logic                      wfout_axis_tvalid,
  output logic                      wfout_axis_tlast,
  output logic [DATA_WIDTH/8-1:0]   wfout_axis_tkeep,
  input  logic                      wfout_axis_tready,
  output logic [2**SLOT_BITS-1:0]   slot_valid,
  output logic                      wf_done,
  output logic [1:0]                cmd_err
);
  localparam int WF_SLOTS = 2**SLOT_BITS;
  localparam int DEPTH    = 2**ADDR_WIDTH;
  localparam int LW       = ADDR_WIDTH + 1;

  typedef enum logic       {W_IDLE, W_LOAD} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_PLAY, R_GAP} r_state_t;

  logic [DATA_WIDTH-1:0] mem [0:WF_SLOTS*DEPTH-1];
  logic [LW-1:0]         slot_len [WF_SLOTS];

  w_state_t              w_state;
  logic [SLOT_BITS-1:0]  w_slot;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [LW-1:0]         w_len;
  logic                  wr_err;

  r_state_t              r_state;
  logic [SLOT_BITS-1:0]  r_slot;
  logic [LW-1:0]         r_len;
  logic [31:0]           r_gap, o_rep, gap_cnt, iss_rep;
  logic                  iss_active, rd_inflight, rd_last, rd_err;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic [DATA_WIDTH-1:0] rd_data, out_data, sk_data;
  logic                  out_valid, out_last, sk_valid, sk_last;

  logic [SLOT_BITS-1:0]  cmd_slot;
  logic [31:0]           cmd_len_raw, cmd_rep, cmd_gap, cmd_rep_eff;
  logic [LW-1:0]         cmd_len;
  logic                  w_req, w_reject, w_accept, r_req, r_reject, r_accept;
  logic                  w_beat, w_end, pop, issue, iss_last;
  logic [1:0]            occ;
  logic                  unused_bits;

  assign cmd_slot    = waveform_parameters[96 +: SLOT_BITS];
  assign cmd_len_raw = waveform_parameters[31:0];
  assign cmd_rep     = waveform_parameters[63:32];
  assign cmd_gap     = waveform_parameters[95:64];
  assign cmd_rep_eff = (cmd_rep == 32'd0) ? 32'd1 : cmd_rep;
  assign unused_bits = ^{wfin_axis_tkeep, waveform_parameters[127:96+SLOT_BITS]};

  always_comb begin
    cmd_len = cmd_len_raw[LW-1:0];
    if (cmd_len_raw == 32'd0)           cmd_len = LW'(1);
    else if (cmd_len_raw > 32'(DEPTH))  cmd_len = LW'(DEPTH);
  end

  // Both requests share one parameter word, so a same-cycle write+read always targets one slot.
  assign w_req    = init_wf_write & wf_write_ready;
  assign w_reject = (r_state != R_IDLE) && (r_slot == cmd_slot);
  assign w_accept = w_req & ~w_reject;
  assign r_req    = init_wf_read & wf_read_ready;
  assign r_reject = (WRITE_BEFORE_READ && !slot_valid[cmd_slot]) ||
                    ((w_state == W_LOAD) && (w_slot == cmd_slot)) || w_accept;
  assign r_accept = r_req & ~r_reject;

  assign wf_write_ready   = (w_state == W_IDLE);
  assign wf_read_ready    = (r_state == R_IDLE);
  assign wfin_axis_tready = (w_state == W_LOAD);
  assign w_beat = wfin_axis_tvalid & wfin_axis_tready;
  assign w_end  = w_beat & (wfin_axis_tlast | ({1'b0, w_addr} == w_len - LW'(1)));
  assign cmd_err = {rd_err, wr_err};

  always_ff @(posedge clk_in1) begin
    if (w_beat) mem[{w_slot, w_addr}] <= wfin_axis_tdata;
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      w_state    <= W_IDLE;
      w_slot     <= '0;
      w_addr     <= '0;
      w_len      <= '0;
      wr_err     <= 1'b0;
      slot_valid <= '0;
      for (int i = 0; i < WF_SLOTS; i++) slot_len[i] <= '0;
    end else begin
      wr_err <= w_req & w_reject;
      case (w_state)
        W_IDLE: if (w_accept) begin
          w_state              <= W_LOAD;
          w_slot               <= cmd_slot;
          w_len                <= cmd_len;
          w_addr               <= '0;
          slot_valid[cmd_slot] <= 1'b0;
        end
        W_LOAD: if (w_beat) begin
          w_addr <= w_addr + 1'b1;
          if (w_end) begin
            w_state            <= W_IDLE;
            slot_len[w_slot]   <= {1'b0, w_addr} + LW'(1);
            slot_valid[w_slot] <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Output side: head register plus skid entry; BRAM reads are issued on credit so
  // head+skid+in-flight never exceeds two, giving full rate without a tready->tvalid path.
  assign wfout_axis_tvalid = out_valid & (r_state == R_PLAY);
  assign wfout_axis_tdata  = out_data;
  assign wfout_axis_tlast  = out_last;
  assign wfout_axis_tkeep  = '1;
  assign pop      = wfout_axis_tvalid & wfout_axis_tready;
  assign occ      = 2'(out_valid) + 2'(sk_valid) + 2'(rd_inflight);
  assign issue    = iss_active && ((occ < 2'd2) || (pop && occ == 2'd2));
  assign iss_last = ({1'b0, iss_addr} == r_len - LW'(1));

  always_ff @(posedge clk_in1) begin
    if (issue) rd_data <= mem[{r_slot, iss_addr}];
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      r_state     <= R_IDLE;
      r_slot      <= '0;
      r_len       <= '0;
      r_gap       <= '0;
      o_rep       <= '0;
      gap_cnt     <= '0;
      iss_active  <= 1'b0;
      iss_addr    <= '0;
      iss_rep     <= '0;
      rd_inflight <= 1'b0;
      rd_last     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      sk_valid    <= 1'b0;
      sk_data     <= '0;
      sk_last     <= 1'b0;
      wf_done     <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      rd_err      <= r_req & r_reject;
      wf_done     <= 1'b0;
      rd_inflight <= issue;
      if (issue) begin
        rd_last <= iss_last;
        if (iss_last) begin
          iss_addr <= '0;
          if (iss_rep == 32'd1) iss_active <= 1'b0;
          else                  iss_rep    <= iss_rep - 32'd1;
        end else begin
          iss_addr <= iss_addr + 1'b1;
        end
      end

      if (pop) begin
        if (sk_valid) begin
          out_data  <= sk_data;
          out_last  <= sk_last;
          out_valid <= 1'b1;
          sk_valid  <= rd_inflight;
          if (rd_inflight) begin
            sk_data <= rd_data;
            sk_last <= rd_last;
          end
        end else begin
          out_valid <= rd_inflight;
          out_data  <= rd_data;
          out_last  <= rd_last;
        end
      end else if (!out_valid) begin
        out_valid <= rd_inflight;
        out_data  <= rd_data;
        out_last  <= rd_last;
      end else if (rd_inflight) begin
        sk_valid <= 1'b1;
        sk_data  <= rd_data;
        sk_last  <= rd_last;
      end

      case (r_state)
        R_IDLE: if (r_accept) begin
          r_state    <= R_PLAY;
          r_slot     <= cmd_slot;
          r_len      <= (slot_len[cmd_slot] == '0) ? LW'(1) : slot_len[cmd_slot];
          r_gap      <= cmd_gap;
          o_rep      <= cmd_rep_eff;
          iss_rep    <= cmd_rep_eff;
          iss_addr   <= '0;
          iss_active <= 1'b1;
        end
        R_PLAY: if (pop && out_last) begin
          if (o_rep == 32'd1) begin
            wf_done <= 1'b1;
            r_state <= R_IDLE;
          end else begin
            o_rep <= o_rep - 32'd1;
            if (r_gap != 32'd0) begin
              r_state <= R_GAP;
              gap_cnt <= r_gap;
            end
          end
        end
        R_GAP: begin
          gap_cnt <= gap_cnt - 32'd1;
          if (gap_cnt == 32'd1) r_state <= R_PLAY;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_waveform_stream_mc.sv
// tb/tb_waveform_stream_mc.sv - scoreboard bench for waveform_stream_mc
`timescale 1ns/1ps
module tb_waveform_stream_mc;
  localparam int NS = 4;
  localparam int DEPTH = 256;

  logic         clk_in1 = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] waveform_parameters = '0;
  logic         init_wf_write = 1'b0, init_wf_read = 1'b0;
  logic         wf_write_ready, wf_read_ready;
  logic [31:0]  wfin_axis_tdata = '0;
  logic         wfin_axis_tvalid = 1'b0, wfin_axis_tlast = 1'b0;
  logic [3:0]   wfin_axis_tkeep = '0;
  logic         wfin_axis_tready;
  logic [31:0]  wfout_axis_tdata;
  logic         wfout_axis_tvalid, wfout_axis_tlast;
  logic [3:0]   wfout_axis_tkeep;
  logic         wfout_axis_tready = 1'b1;
  logic [3:0]   slot_valid;
  logic         wf_done;
  logic [1:0]   cmd_err;

  waveform_stream_mc dut (
    .clk_in1(clk_in1), .reset(reset), .waveform_parameters(waveform_parameters),
    .init_wf_write(init_wf_write), .wf_write_ready(wf_write_ready),
    .init_wf_read(init_wf_read), .wf_read_ready(wf_read_ready),
    .wfin_axis_tdata(wfin_axis_tdata), .wfin_axis_tvalid(wfin_axis_tvalid),
    .wfin_axis_tlast(wfin_axis_tlast), .wfin_axis_tkeep(wfin_axis_tkeep),
    .wfin_axis_tready(wfin_axis_tready),
    .wfout_axis_tdata(wfout_axis_tdata), .wfout_axis_tvalid(wfout_axis_tvalid),
    .wfout_axis_tlast(wfout_axis_tlast), .wfout_axis_tkeep(wfout_axis_tkeep),
    .wfout_axis_tready(wfout_axis_tready),
    .slot_valid(slot_valid), .wf_done(wf_done), .cmd_err(cmd_err)
  );

  always #5 clk_in1 = ~clk_in1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          idle;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, failures = 0;
  logic [31:0] model_mem [NS][DEPTH];
  int          model_len [NS];
  int          done_cnt = 0, pop_cnt = 0, done_base = 0;
  int          tready_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [127:0] mkp(input int len, input int rep, input int gap, input int slot);
    logic [127:0] p;
    p = '0;
    p[127:98] = 30'($urandom);
    p[31:0]   = len;
    p[63:32]  = rep;
    p[95:64]  = gap;
    p[97:96]  = slot[1:0];
    return p;
  endfunction

  initial forever begin
    @(posedge clk_in1);
    #2;
    wfout_axis_tready = (tready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on every accepted output beat and checks stall stability.
  initial begin
    bit          stall;
    int          idle;
    logic [31:0] held_d;
    logic        held_l;
    exp_t        e;
    stall = 0;
    idle = 0;
    forever begin
      @(negedge clk_in1);
      if (reset) begin
        stall = 0;
        idle = 0;
        continue;
      end
      if (wf_done) done_cnt++;
      if (stall) begin
        check("stall_valid_held", wfout_axis_tvalid, 1);
        if (wfout_axis_tvalid) begin
          check("stall_data", wfout_axis_tdata, held_d);
          check("stall_last", wfout_axis_tlast, held_l);
        end
      end
      if (wfout_axis_tvalid) begin
        if (wfout_axis_tready) begin
          stall = 0;
          check("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_data", wfout_axis_tdata, e.data);
            check("out_last", wfout_axis_tlast, e.last);
            check("out_tkeep", wfout_axis_tkeep, 4'hf);
            if (e.idle >= 0) check("idle_cycles", idle, e.idle);
            pop_cnt++;
          end
          idle = 0;
        end else begin
          stall = 1;
          held_d = wfout_axis_tdata;
          held_l = wfout_axis_tlast;
        end
      end else begin
        stall = 0;
        idle++;
      end
    end
  end

  task automatic cmd_write(input int slot, input int len, input bit exp_rej);
    @(negedge clk_in1);
    waveform_parameters = mkp(len, $urandom, $urandom, slot);
    init_wf_write = 1'b1;
    @(posedge clk_in1);
    @(negedge clk_in1);
    init_wf_write = 1'b0;
    check("wr_cmd_err", cmd_err[0], exp_rej);
    check("wr_ready_after_cmd", wf_write_ready, exp_rej);
    if (!exp_rej) check("slot_valid_cleared", slot_valid[slot], 0);
  endtask

  task automatic feed_beats(input int slot, input int len, input int nbeats, input int tlast_at, input bit seq);
    int exp_n, acc, t;
    logic [31:0] d;
    exp_n = (len == 0) ? 1 : ((len > DEPTH) ? DEPTH : len);
    if (tlast_at > 0 && tlast_at < exp_n) exp_n = tlast_at;
    acc = 0;
    for (int i = 0; i < nbeats; i++) begin
      d = seq ? 32'(i + 1) : $urandom;
      if (i < exp_n) model_mem[slot][i] = d;
      wfin_axis_tdata  = d;
      wfin_axis_tvalid = 1'b1;
      wfin_axis_tlast  = (i + 1 == tlast_at);
      wfin_axis_tkeep  = 4'($urandom);
      t = 0;
      while (!wfin_axis_tready && t < 20) begin
        @(negedge clk_in1);
        t++;
      end
      if (!wfin_axis_tready) break;
      @(posedge clk_in1);
      acc++;
      @(negedge clk_in1);
      if (wfin_axis_tlast) break;
    end
    wfin_axis_tvalid = 1'b0;
    wfin_axis_tlast  = 1'b0;
    check("load_beats", acc, exp_n);
    check("slot_valid_set", slot_valid[slot], 1);
    check("wr_ready_idle", wf_write_ready, 1);
    model_len[slot] = exp_n;
  endtask

  task automatic cmd_read(input int slot, input int rep, input int gap, input bit exp_rej, input bit chk_lat);
    int n, reff, len;
    exp_t e;
    @(negedge clk_in1);
    waveform_parameters = mkp($urandom_range(1, 300), rep, gap, slot);
    init_wf_read = 1'b1;
    done_base = done_cnt;
    if (!exp_rej) begin
      reff = (rep == 0) ? 1 : rep;
      len = model_len[slot];
      for (int r = 0; r < reff; r++)
        for (int i = 0; i < len; i++) begin
          e.data = model_mem[slot][i];
          e.last = (i == len - 1);
          e.idle = (i != 0) ? 0 : ((r == 0) ? -1 : gap);
          exp_q.push_back(e);
        end
    end
    @(posedge clk_in1);
    @(negedge clk_in1);
    init_wf_read = 1'b0;
    check("rd_cmd_err", cmd_err[1], exp_rej);
    check("rd_ready_after_cmd", wf_read_ready, exp_rej);
    if (chk_lat && !exp_rej) begin
      n = 0;
      while (!wfout_axis_tvalid && n < 10) begin
        @(negedge clk_in1);
        n++;
      end
      check("first_word_latency", n, 2);
    end
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < budget) begin
      @(negedge clk_in1);
      t++;
    end
    check("stream_drained", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk_in1);
    check("wf_done_pulses", done_cnt - done_base, 1);
    check("rd_ready_back", wf_read_ready, 1);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk_in1);
    #1 reset = 1'b0;
    @(negedge clk_in1);
    check("rst_write_ready", wf_write_ready, 1);
    check("rst_read_ready", wf_read_ready, 1);
    check("rst_tvalid", wfout_axis_tvalid, 0);
    check("rst_slot_valid", slot_valid, 0);
    check("rst_done_err", {wf_done, cmd_err}, 0);
    check("rst_in_tready", wfin_axis_tready, 0);

    cmd_write(0, 'h80, 0);
    feed_beats(0, 'h80, 128, 128, 1);
    check("slot_valid_after_load0", slot_valid, 4'b0001);

    tready_mode = 0;
    cmd_read(0, 1, 0, 0, 1);
    wait_done(1000);

    cmd_read(0, 3, 5, 0, 1);
    wait_done(2000);

    tready_mode = 1;
    cmd_read(0, 0, 0, 0, 1);
    wait_done(2000);

    done_base = done_cnt;
    cmd_read(2, 1, 0, 1, 0);
    repeat (6) @(negedge clk_in1);
    check("unloaded_no_output", wfout_axis_tvalid, 0);
    check("unloaded_rd_ready", wf_read_ready, 1);
    check("unloaded_no_done", done_cnt - done_base, 0);

    cmd_write(1, 'h80, 0);
    feed_beats(1, 'h80, 40, 10, 0);
    cmd_read(1, 1, 0, 0, 0);
    wait_done(500);

    cmd_read(0, 2, 3, 0, 0);
    cmd_write(0, 'h80, 1);
    cmd_write(3, 60, 0);
    feed_beats(3, 60, 60, 60, 0);
    wait_done(2000);
    tready_mode = 0;
    cmd_read(3, 2, 0, 0, 1);
    wait_done(1000);

    @(negedge clk_in1);
    waveform_parameters = mkp('h80, 2, 0, 2);
    init_wf_write = 1'b1;
    init_wf_read = 1'b1;
    @(posedge clk_in1);
    @(negedge clk_in1);
    init_wf_write = 1'b0;
    init_wf_read = 1'b0;
    check("same_cycle_cmd_err", cmd_err, 2'b10);
    check("same_cycle_wr_busy", wf_write_ready, 0);
    check("same_cycle_rd_idle", wf_read_ready, 1);
    feed_beats(2, 'h80, 5, 5, 0);
    cmd_read(2, 2, 0, 0, 1);
    wait_done(500);

    cmd_write(2, 1000, 0);
    feed_beats(2, 1000, 258, 0, 0);
    tready_mode = 1;
    cmd_read(2, 1, 0, 0, 0);
    wait_done(2000);

    cmd_write(1, 0, 0);
    feed_beats(1, 0, 3, 0, 0);
    cmd_read(1, 3, 0, 0, 1);
    wait_done(200);

    tready_mode = 0;
    cmd_read(0, 2, 0, 0, 0);
    t = 0;
    while (pop_cnt < done_base + 0 && 0) t++;
    t = pop_cnt;
    for (int k = 0; k < 500 && pop_cnt < t + 50; k++) @(negedge clk_in1);
    check("mid_burst_reached", pop_cnt - t >= 50, 1);
    @(posedge clk_in1);
    #1 reset = 1'b1;
    @(posedge clk_in1);
    @(negedge clk_in1);
    check("reset_tvalid_drop", wfout_axis_tvalid, 0);
    check("reset_slot_valid", slot_valid, 0);
    check("reset_ready", {wf_write_ready, wf_read_ready}, 2'b11);
    exp_q.delete();
    @(posedge clk_in1);
    #1 reset = 1'b0;
    cmd_read(0, 1, 0, 1, 0);
    repeat (5) @(negedge clk_in1);
    check("post_reset_no_output", wfout_axis_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/waveform_stream_mc.md
Name: waveform_stream_mc

Overview:
- Multi-slot successor to waveform_stream: holds WF_SLOTS independent waveforms in one inferred dual-port BRAM. Each slot is DEPTH = 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Each slot is loaded over an AXI-Stream input and replayed on an AXI-Stream output.
- Replay supports a per-command repeat count and an idle gap between repeats.
- Sits between the host/ADC data FIFOs and the DAC/chirp path, in the fmc_tclk domain.

Parameters:
- DATA_WIDTH, 32, stream and sample width; multiple of 8.
- ADDR_WIDTH, 8, log2 of words per slot.
- SLOT_BITS, 2, log2 of slot count (WF_SLOTS = 2^SLOT_BITS).
- WRITE_BEFORE_READ, 1, 1 = reject playback of a slot that has never been loaded.

Ports:
- clk_in1  in  1  single clock.
- reset  in  1  synchronous, active-high.
- waveform_parameters  in  128  command word, sampled on command accept:
  - [31:0] length in words
  - [63:32] repeat count
  - [95:64] gap cycles
  - [96+SLOT_BITS-1:96] slot
- init_wf_write  in  1  load command request.
- wf_write_ready  out  1  load FSM idle; command accepted.
- init_wf_read  in  1  playback command request.
- wf_read_ready  out  1  playback FSM idle; command accepted.
- wfin_axis_tdata/tvalid/tlast/tkeep/tready  in/in/in/in/out  DATA_WIDTH/1/1/DATA_WIDTH/8/1  load stream.
- wfout_axis_tdata/tvalid/tlast/tkeep/tready  out/out/out/out/in  DATA_WIDTH/1/1/DATA_WIDTH/8/1  playback stream.
- slot_valid  out  WF_SLOTS  per-slot loaded flag.
- wf_done  out  1  one-cycle pulse after the final word of the final repeat is accepted.
- cmd_err  out  2  one-cycle pulses: [0] write rejected, [1] read rejected.

Behaviour:
- Reset: all outputs 0 except wf_write_ready=1 and wf_read_ready=1.
  - slot_valid and stored slot lengths clear; both FSMs go idle.
  - Reset mid-operation aborts immediately; wfout_axis_tvalid drops the cycle after reset is sampled.
- Command accept: request & ready on a rising edge. The request may be held; only one accept per idle period.
- Length rules: length 0 becomes 1; length > DEPTH is clamped to DEPTH. Repeat 0 is treated as 1. Gap is used as-is; gap 0 means back-to-back repeats.
- Load FSM:
  - W_IDLE:
    - Accept -> W_LOAD, latching slot and length; write address resets to 0.
    - Reject with cmd_err[0] if the slot equals the slot currently in playback (R_PLAY or R_GAP).
  - W_LOAD:
    - wfin_axis_tready=1. Each beat (tvalid & tready) writes BRAM[slot][addr] and increments addr. tkeep is ignored; full words are stored.
    - Exits to W_IDLE on a beat with tlast, or on the beat where addr = length-1, whichever comes first.
    - Stored slot length = beats written. slot_valid[slot] is set the cycle after exit.
    - Early tlast shortens the stored length. Missing tlast at length truncates silently; further input beats see tready=0.
  - During W_LOAD, slot_valid[slot] is cleared.
- Playback FSM:
  - R_IDLE:
    - Accept -> R_PLAY, latching slot, repeat, gap.
    - Reject with cmd_err[1] if WRITE_BEFORE_READ=1 and slot_valid[slot]=0, or if the slot is in W_LOAD.
    - Read length = the stored slot length; the command length field is ignored for reads.
  - R_PLAY:
    - BRAM read latency is 1 cycle. A 2-entry skid/output register makes tvalid/tdata independent of tready.
    - Data and tvalid are held stable while tready=0.
    - First word is valid 2 cycles after accept.
    - tlast=1 on the last word of every repeat. tkeep is all ones.
  - After the last word of a repeat is accepted:
    - if repeats remain and gap>0 -> R_GAP;
    - if repeats remain and gap=0 -> R_PLAY at addr 0 with no bubble;
    - otherwise wf_done pulses and the FSM returns to R_IDLE.
  - R_GAP: tvalid=0 for exactly gap cycles, then -> R_PLAY.
- Concurrent operation: a load of slot A and playback of slot B (A≠B) run simultaneously with full throughput on both. Write and read commands accepted in the same cycle for the same slot: the write is accepted, the read is rejected.
- Counters: the repeat counter is 32-bit and the gap counter is 32-bit; neither wraps. A repeat value of 0xFFFFFFFF plays 2^32-1 times.

Test Plan:
- Reset, then load slot 0 with length 0x80 using data 1..128, tlast on beat 128 -> 128 beats accepted; slot_valid=4'b0001; wf_write_ready returns 1.
- Read slot 0 with repeat 1, gap 0, tready held 1 -> 128 words 1..128 on consecutive cycles, first word 2 cycles after accept; tlast on word 128; wf_done pulses once.
- Read slot 0 with repeat 3, gap 5 -> three 128-word bursts, each ending in tlast; exactly 5 idle cycles between bursts; wf_done after the third burst.
- Read slot 0 with tready toggling in a pseudo-random pattern -> no word dropped or duplicated; the output sequence equals 1..128; tdata stays stable while stalled.
- Read slot 2 before it has been loaded -> cmd_err[1] pulses; no output; wf_read_ready stays 1. Load slot 1 with tlast at beat 10 against length 0x80 -> playback of slot 1 yields 10 words with tlast on the 10th.
- During playback of slot 0: issue a write to slot 0 -> cmd_err[0] pulses. Load slot 3 concurrently -> both streams complete correctly. Assert reset mid-burst -> tvalid=0 next cycle and slot_valid=0.
